// File: rtl/axi4lite_ram_slave.sv
// -----------------------------------------------------------------------------
// axi4lite_ram_slave
//
// AXI4-Lite responder in front of a word-organised, byte-strobed RAM. It is
// used as data memory for the core's load/store unit. It also serves as a
// template for other memory-mapped slaves.
//
// The write and read channels each have their own state machine, so one write
// and one read can be outstanding at the same time. All handshake outputs are
// registered. They therefore come up one edge after reset is released.
//
// Parameters
//   ADDR_W  word-index bits; depth is 2**ADDR_W 32-bit words
//   BASE    region base; only BASE[31:2+ADDR_W] is compared
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   w_addr/w_avalid/w_aready   write address channel
//   w_data/w_strb/w_valid/w_ready   write data channel
//   w_bvalid/w_bresp/w_bready       write response channel
//   r_addr/r_avalid/r_aready   read address channel
//   r_data/r_resp/r_valid/r_ready   read data channel
//
// Responses: OKAY (2'b00) when the address falls inside the region,
// SLVERR (2'b10) otherwise. addr[1:0] is ignored; byte lanes come from strb.
// -----------------------------------------------------------------------------
module axi4lite_ram_slave #(
  parameter int unsigned ADDR_W = 10,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  // write channels
  input  logic [31:0] w_addr,
  input  logic        w_avalid,
  input  logic [31:0] w_data,
  input  logic [3:0]  w_strb,
  input  logic        w_valid,
  input  logic        w_bready,
  output logic        w_aready,
  output logic        w_ready,
  output logic        w_bvalid,
  output logic [1:0]  w_bresp,
  // read channels
  input  logic [31:0] r_addr,
  input  logic        r_avalid,
  input  logic        r_ready,
  output logic        r_aready,
  output logic        r_valid,
  output logic [31:0] r_data,
  output logic [1:0]  r_resp
);

  localparam int unsigned DEPTH       = 2 ** ADDR_W;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_WAIT_DATA = 2'd1,
    W_WAIT_ADDR = 2'd2,
    W_RESP      = 2'd3
  } w_state_e;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_VALID = 1'b1
  } r_state_e;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic              w_addr_hit;
  logic [ADDR_W-1:0] w_addr_idx;
  logic              r_addr_hit;
  logic [ADDR_W-1:0] r_addr_idx;
  logic              unused_addr_bits;

  assign w_addr_hit = (w_addr[31:2+ADDR_W] == BASE[31:2+ADDR_W]);
  assign w_addr_idx = w_addr[2+ADDR_W-1:2];
  assign r_addr_hit = (r_addr[31:2+ADDR_W] == BASE[31:2+ADDR_W]);
  assign r_addr_idx = r_addr[2+ADDR_W-1:2];

  // Sub-word address bits carry no meaning here; byte selection is by strobe.
  assign unused_addr_bits = ^{w_addr[1:0], r_addr[1:0]};

  // ---------------------------------------------------------------------------
  // Storage (contents are deliberately not reset)
  // ---------------------------------------------------------------------------
  logic [31:0] mem_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Write channel state
  // ---------------------------------------------------------------------------
  w_state_e          w_state_q, w_state_d;
  logic              w_aready_q, w_aready_d;
  logic              w_ready_q, w_ready_d;
  logic              w_bvalid_q, w_bvalid_d;
  logic [1:0]        w_bresp_q, w_bresp_d;
  // Half of a split transfer, held until the other half arrives.
  logic              w_hit_q, w_hit_d;
  logic [ADDR_W-1:0] w_idx_q, w_idx_d;
  logic [31:0]       w_data_q, w_data_d;
  logic [3:0]        w_strb_q, w_strb_d;

  logic              w_aw_hs;
  logic              w_wd_hs;

  logic              commit_en;
  logic              commit_hit;
  logic [ADDR_W-1:0] commit_idx;
  logic [31:0]       commit_data;
  logic [3:0]        commit_strb;

  assign w_aw_hs = w_aready_q & w_avalid;
  assign w_wd_hs = w_ready_q & w_valid;

  always_comb begin
    w_state_d   = w_state_q;
    w_hit_d     = w_hit_q;
    w_idx_d     = w_idx_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    w_bresp_d   = w_bresp_q;
    commit_en   = 1'b0;
    // Default commit sources are the live bus; the wait states substitute
    // whichever half was latched earlier.
    commit_hit  = w_addr_hit;
    commit_idx  = w_addr_idx;
    commit_data = w_data;
    commit_strb = w_strb;

    case (w_state_q)
      W_IDLE: begin
        if (w_aw_hs && w_wd_hs) begin
          commit_en = 1'b1;
          w_state_d = W_RESP;
        end else if (w_aw_hs) begin
          w_hit_d   = w_addr_hit;
          w_idx_d   = w_addr_idx;
          w_state_d = W_WAIT_DATA;
        end else if (w_wd_hs) begin
          w_data_d  = w_data;
          w_strb_d  = w_strb;
          w_state_d = W_WAIT_ADDR;
        end
      end
      W_WAIT_DATA: begin
        if (w_wd_hs) begin
          commit_en  = 1'b1;
          commit_hit = w_hit_q;
          commit_idx = w_idx_q;
          w_state_d  = W_RESP;
        end
      end
      W_WAIT_ADDR: begin
        if (w_aw_hs) begin
          commit_en   = 1'b1;
          commit_data = w_data_q;
          commit_strb = w_strb_q;
          w_state_d   = W_RESP;
        end
      end
      W_RESP: begin
        if (w_bvalid_q && w_bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: begin
        w_state_d = W_IDLE;
      end
    endcase

    if (commit_en) begin
      w_bresp_d = commit_hit ? RESP_OKAY : RESP_SLVERR;
    end

    // Readies are derived from the next state so they are registered yet
    // already correct in the first cycle of each state. In idle they are
    // raised unconditionally: the initiator waits for both before driving.
    w_aready_d = (w_state_d == W_IDLE) || (w_state_d == W_WAIT_ADDR);
    w_ready_d  = (w_state_d == W_IDLE) || (w_state_d == W_WAIT_DATA);
    w_bvalid_d = (w_state_d == W_RESP);
  end

  // ---------------------------------------------------------------------------
  // Read channel state
  // ---------------------------------------------------------------------------
  r_state_e    r_state_q, r_state_d;
  logic        r_aready_q, r_aready_d;
  logic        r_valid_q, r_valid_d;
  logic [31:0] r_data_q, r_data_d;
  logic [1:0]  r_resp_q, r_resp_d;
  logic        r_ar_hs;
  logic [31:0] r_rd_word;

  assign r_ar_hs = r_aready_q & r_avalid;
  // Asynchronous array read sampled at the handshake edge. A write committing
  // on that same edge has not landed yet, so the read returns the old word.
  assign r_rd_word = mem_q[r_addr_idx];

  always_comb begin
    r_state_d = r_state_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;

    case (r_state_q)
      R_IDLE: begin
        if (r_ar_hs) begin
          r_data_d  = r_addr_hit ? r_rd_word : 32'h0000_0000;
          r_resp_d  = r_addr_hit ? RESP_OKAY : RESP_SLVERR;
          r_state_d = R_VALID;
        end
      end
      R_VALID: begin
        if (r_valid_q && r_ready) begin
          r_state_d = R_IDLE;
        end
      end
      default: begin
        r_state_d = R_IDLE;
      end
    endcase

    r_aready_d = (r_state_d == R_IDLE);
    r_valid_d  = (r_state_d == R_VALID);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q  <= W_IDLE;
      w_aready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      w_bvalid_q <= 1'b0;
      w_bresp_q  <= 2'b00;
      r_state_q  <= R_IDLE;
      r_aready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_data_q   <= 32'h0000_0000;
      r_resp_q   <= 2'b00;
    end else begin
      w_state_q  <= w_state_d;
      w_aready_q <= w_aready_d;
      w_ready_q  <= w_ready_d;
      w_bvalid_q <= w_bvalid_d;
      w_bresp_q  <= w_bresp_d;
      r_state_q  <= r_state_d;
      r_aready_q <= r_aready_d;
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
    end
  end

  // Latched halves of a split write need no reset: a reset returns the FSM to
  // idle, where they are never consumed before being overwritten.
  always_ff @(posedge clk) begin
    w_hit_q  <= w_hit_d;
    w_idx_q  <= w_idx_d;
    w_data_q <= w_data_d;
    w_strb_q <= w_strb_d;
  end

  always_ff @(posedge clk) begin
    if (commit_en && commit_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (commit_strb[i]) begin
          mem_q[commit_idx][8*i +: 8] <= commit_data[8*i +: 8];
        end
      end
    end
  end

  assign w_aready = w_aready_q;
  assign w_ready  = w_ready_q;
  assign w_bvalid = w_bvalid_q;
  assign w_bresp  = w_bresp_q;
  assign r_aready = r_aready_q;
  assign r_valid  = r_valid_q;
  assign r_data   = r_data_q;
  assign r_resp   = r_resp_q;

endmodule

// File: tb/tb_axi4lite_ram_slave.sv
module tb_axi4lite_ram_slave;

  logic        clk;
  logic        rst_n;
  logic [31:0] w_addr;
  logic        w_avalid;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_valid;
  logic        w_bready;
  logic        w_aready;
  logic        w_ready;
  logic        w_bvalid;
  logic [1:0]  w_bresp;
  logic [31:0] r_addr;
  logic        r_avalid;
  logic        r_ready;
  logic        r_aready;
  logic        r_valid;
  logic [31:0] r_data;
  logic [1:0]  r_resp;

  int checks;
  int failures;

  // Reference memory: only words 0..15 are ever targeted in range.
  logic [31:0] model_mem [1024];

  axi4lite_ram_slave #(.ADDR_W(10), .BASE(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .w_addr(w_addr), .w_avalid(w_avalid), .w_data(w_data), .w_strb(w_strb),
    .w_valid(w_valid), .w_bready(w_bready),
    .w_aready(w_aready), .w_ready(w_ready), .w_bvalid(w_bvalid), .w_bresp(w_bresp),
    .r_addr(r_addr), .r_avalid(r_avalid), .r_ready(r_ready),
    .r_aready(r_aready), .r_valid(r_valid), .r_data(r_data), .r_resp(r_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- model ----------------
  function automatic logic model_hit(input logic [31:0] a);
    return (a >> 12) == 32'd0;
  endfunction

  function automatic logic [1:0] model_resp(input logic [31:0] a);
    return model_hit(a) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return model_hit(a) ? model_mem[a[11:2]] : 32'd0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    if (model_hit(a)) begin
      w = model_mem[a[11:2]];
      for (int i = 0; i < 4; i++)
        if (s[i]) w[8*i +: 8] = d[8*i +: 8];
      model_mem[a[11:2]] = w;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_w_idle();
    int n;
    n = 0;
    while (!(w_aready && w_ready) && n < 20) begin step(); n++; end
  endtask

  task automatic wait_r_idle();
    int n;
    n = 0;
    while (!r_aready && n < 20) begin step(); n++; end
  endtask

  // Returns cycles from the handshake edge to bvalid (0 = next cycle), -1 on timeout.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat);
    wait_w_idle();
    w_addr = a; w_data = d; w_strb = s; w_avalid = 1'b1; w_valid = 1'b1;
    step();
    w_avalid = 1'b0; w_valid = 1'b0;
    lat = 0;
    while (!w_bvalid && lat < 20) begin step(); lat++; end
    resp = w_bresp;
    if (!w_bvalid) lat = -1;
    step();
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output int lat);
    wait_r_idle();
    r_addr = a; r_avalid = 1'b1;
    step();
    r_avalid = 1'b0;
    lat = 0;
    while (!r_valid && lat < 20) begin step(); lat++; end
    d = r_data; resp = r_resp;
    if (!r_valid) lat = -1;
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    w_addr = '0; w_avalid = 1'b0; w_data = '0; w_strb = '0; w_valid = 1'b0; w_bready = 1'b1;
    r_addr = '0; r_avalid = 1'b0; r_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({w_aready, w_ready, w_bvalid, w_bresp, r_aready, r_valid, r_data, r_resp} !== 40'd0) begin
        failures++;
        $display("FAIL reset_outputs cycle %0d: got %h want 0", k,
                 {w_aready, w_ready, w_bvalid, w_bresp, r_aready, r_valid, r_data, r_resp});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({w_aready, w_ready, r_aready} !== 3'b000) begin
      failures++;
      $display("FAIL readies_before_edge: got %b want 000", {w_aready, w_ready, r_aready});
    end
    step();
    checks++;
    if ({w_aready, w_ready, r_aready, w_bvalid, r_valid} !== 5'b11100) begin
      failures++;
      $display("FAIL readies_after_release: got %b want 11100",
               {w_aready, w_ready, r_aready, w_bvalid, r_valid});
    end
  endtask

  task automatic test_preload();
    logic [1:0]  resp;
    int          lat;
    logic [31:0] d;
    for (int i = 0; i < 16; i++) begin
      d = (i == 1) ? 32'h1122_3344 : $urandom;
      bus_write(32'(i) << 2, d, 4'hF, resp, lat);
      model_write(32'(i) << 2, d, 4'hF);
      checks++;
      if (resp !== 2'b00 || lat != 0) begin
        failures++;
        $display("FAIL preload word %0d: resp=%b lat=%0d want resp=00 lat=0", i, resp, lat);
      end
    end
  endtask

  task automatic test_byte_write();
    logic [1:0]  resp;
    int          lat;
    logic [31:0] d;
    bus_write(32'h0000_0005, 32'hAABB_CCDD, 4'b0010, resp, lat);
    model_write(32'h0000_0005, 32'hAABB_CCDD, 4'b0010);
    checks++;
    if (resp !== 2'b00 || lat != 0) begin
      failures++;
      $display("FAIL byte_write_resp: resp=%b lat=%0d want resp=00 lat=0", resp, lat);
    end
    bus_read(32'h0000_0004, d, resp, lat);
    checks++;
    if (d !== 32'h1122_CC44 || resp !== 2'b00 || lat != 0) begin
      failures++;
      $display("FAIL byte_write_readback: data=%h resp=%b lat=%0d want 1122cc44 00 0", d, resp, lat);
    end
  endtask

  task automatic test_split();
    logic [31:0] a, d, rd;
    logic [3:0]  s;
    logic [1:0]  resp;
    int          lat;
    a = 32'h0000_0008;
    d = $urandom;
    s = 4'($urandom_range(1, 15));
    wait_w_idle();
    w_data = d; w_strb = s; w_valid = 1'b1;
    step();
    w_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({w_aready, w_ready, w_bvalid} !== 3'b100) begin
        failures++;
        $display("FAIL split_wait_addr cycle %0d: aready,ready,bvalid=%b want 100", k,
                 {w_aready, w_ready, w_bvalid});
      end
      if (k == 0) begin
        step();
      end
    end
    w_addr = a; w_avalid = 1'b1;
    step();
    w_avalid = 1'b0;
    model_write(a, d, s);
    checks++;
    if (w_bvalid !== 1'b1 || w_bresp !== 2'b00) begin
      failures++;
      $display("FAIL split_bvalid: bvalid=%b bresp=%b want 1 00", w_bvalid, w_bresp);
    end
    step();
    checks++;
    if ({w_aready, w_ready, w_bvalid} !== 3'b110) begin
      failures++;
      $display("FAIL split_return_idle: aready,ready,bvalid=%b want 110", {w_aready, w_ready, w_bvalid});
    end
    bus_read(a, rd, resp, lat);
    checks++;
    if (rd !== model_read(a) || resp !== 2'b00) begin
      failures++;
      $display("FAIL split_readback: data=%h resp=%b want %h 00", rd, resp, model_read(a));
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd;
    logic [1:0]  resp;
    int          lat;
    bus_write(32'h0000_1000, $urandom, 4'hF, resp, lat);
    checks++;
    if (resp !== 2'b10 || lat != 0) begin
      failures++;
      $display("FAIL oor_write: bresp=%b lat=%0d want 10 0", resp, lat);
    end
    bus_read(32'h0000_0000, rd, resp, lat);
    checks++;
    if (rd !== model_mem[0] || resp !== 2'b00) begin
      failures++;
      $display("FAIL oor_alias_unchanged: data=%h resp=%b want %h 00", rd, resp, model_mem[0]);
    end
    bus_read(32'h0000_1000, rd, resp, lat);
    checks++;
    if (rd !== 32'd0 || resp !== 2'b10 || lat != 0) begin
      failures++;
      $display("FAIL oor_read: data=%h resp=%b lat=%0d want 0 10 0", rd, resp, lat);
    end
  endtask

  task automatic test_collision();
    logic [31:0] old_w, d, rd;
    logic [1:0]  resp;
    int          lat;
    old_w = model_mem[3];
    d = ~old_w ^ $urandom;
    wait_w_idle();
    wait_r_idle();
    r_ready = 1'b0;
    w_addr = 32'h0000_000C; w_data = d; w_strb = 4'hF; w_avalid = 1'b1; w_valid = 1'b1;
    r_addr = 32'h0000_000C; r_avalid = 1'b1;
    step();
    w_avalid = 1'b0; w_valid = 1'b0; r_avalid = 1'b0;
    model_write(32'h0000_000C, d, 4'hF);
    checks++;
    if (w_bvalid !== 1'b1 || w_bresp !== 2'b00) begin
      failures++;
      $display("FAIL collision_bvalid: bvalid=%b bresp=%b want 1 00", w_bvalid, w_bresp);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (r_valid !== 1'b1 || r_data !== old_w || r_resp !== 2'b00) begin
        failures++;
        $display("FAIL collision_hold cycle %0d: valid=%b data=%h resp=%b want 1 %h 00",
                 k, r_valid, r_data, r_resp, old_w);
      end
      step();
    end
    r_ready = 1'b1;
    step();
    checks++;
    if (r_valid !== 1'b0 || r_aready !== 1'b1) begin
      failures++;
      $display("FAIL collision_release: valid=%b aready=%b want 0 1", r_valid, r_aready);
    end
    bus_read(32'h0000_000C, rd, resp, lat);
    checks++;
    if (rd !== d || resp !== 2'b00) begin
      failures++;
      $display("FAIL collision_new_value: data=%h resp=%b want %h 00", rd, resp, d);
    end
  endtask

  task automatic test_mid_write_reset();
    logic [31:0] rd, d;
    logic [1:0]  resp;
    int          lat;
    wait_w_idle();
    w_addr = 32'h0000_0014; w_avalid = 1'b1;
    step();
    w_avalid = 1'b0;
    checks++;
    if ({w_aready, w_ready} !== 2'b01) begin
      failures++;
      $display("FAIL midreset_wait_data: aready,ready=%b want 01", {w_aready, w_ready});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({w_aready, w_ready, w_bvalid, r_aready, r_valid} !== 5'b00000) begin
      failures++;
      $display("FAIL midreset_outputs: got %b want 00000", {w_aready, w_ready, w_bvalid, r_aready, r_valid});
    end
    w_data = $urandom; w_strb = 4'hF; w_valid = 1'b1;
    step();
    step();
    w_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if ({w_aready, w_ready, w_bvalid} !== 3'b110) begin
      failures++;
      $display("FAIL midreset_after_release: aready,ready,bvalid=%b want 110", {w_aready, w_ready, w_bvalid});
    end
    bus_read(32'h0000_0014, rd, resp, lat);
    checks++;
    if (rd !== model_mem[5] || resp !== 2'b00) begin
      failures++;
      $display("FAIL midreset_word_unchanged: data=%h want %h", rd, model_mem[5]);
    end
    d = $urandom;
    bus_write(32'h0000_0014, d, 4'hF, resp, lat);
    model_write(32'h0000_0014, d, 4'hF);
    bus_read(32'h0000_0014, rd, resp, lat);
    checks++;
    if (rd !== d || resp !== 2'b00) begin
      failures++;
      $display("FAIL midreset_fresh_write: data=%h resp=%b want %h 00", rd, resp, d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, rd;
    logic [1:0]  resp;
    int          lat;
    wait_r_idle();
    r_addr = 32'h0000_001C; r_avalid = 1'b1; r_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (r_valid !== ((k % 2) == 0) || (r_valid && r_data !== model_mem[7])) begin
        failures++;
        $display("FAIL b2b_read cycle %0d: valid=%b data=%h want valid=%0d data=%h",
                 k, r_valid, r_data, (k % 2) == 0, model_mem[7]);
      end
    end
    r_avalid = 1'b0;
    d = $urandom;
    wait_w_idle();
    w_addr = 32'h0000_0020; w_data = d; w_strb = 4'hF; w_avalid = 1'b1; w_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (w_bvalid !== ((k % 2) == 0)) begin
        failures++;
        $display("FAIL b2b_write cycle %0d: bvalid=%b want %0d", k, w_bvalid, (k % 2) == 0);
      end
    end
    w_avalid = 1'b0; w_valid = 1'b0;
    model_write(32'h0000_0020, d, 4'hF);
    bus_read(32'h0000_0020, rd, resp, lat);
    checks++;
    if (rd !== d) begin
      failures++;
      $display("FAIL b2b_write_readback: data=%h want %h", rd, d);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, rd;
    logic [3:0]  s;
    logic [1:0]  resp;
    int          lat;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 7) == 0)
        a = $urandom | 32'h0000_1000;
      else
        a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        bus_write(a, d, s, resp, lat);
        model_write(a, d, s);
        checks++;
        if (resp !== model_resp(a) || lat != 0) begin
          failures++;
          $display("FAIL rand_write it=%0d addr=%h: bresp=%b lat=%0d want %b 0",
                   it, a, resp, lat, model_resp(a));
        end
      end else begin
        bus_read(a, rd, resp, lat);
        checks++;
        if (rd !== model_read(a) || resp !== model_resp(a) || lat != 0) begin
          failures++;
          $display("FAIL rand_read it=%0d addr=%h: data=%h resp=%b lat=%0d want %h %b 0",
                   it, a, rd, resp, lat, model_read(a), model_resp(a));
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_preload();
    test_byte_write();
    test_split();
    test_out_of_range();
    test_collision();
    test_mid_write_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
